// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry pipeline register with skid buffer, registered ready and flush
module pipe_skid_reg #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          CLEAR_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_out_valid;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    state_t           w_state_nxt;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_main_load_in;
    logic             w_main_load_skid;
    logic             w_skid_load_in;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    // Handshake flags are kept in their own flops so ready/valid never pass through decode logic.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_FULL);
        end
    end

    // Next-state and data-steering decode; flush overrides every handshake.
    always_comb begin
        w_state_nxt      = r_state;
        w_main_load_in   = 1'b0;
        w_main_load_skid = 1'b0;
        w_skid_load_in   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_main_load_in = 1'b1;
                    w_state_nxt    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_main_load_in = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_in_xfer) begin
                    w_skid_load_in = 1'b1;
                    w_state_nxt    = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_out_xfer) begin
                    w_main_load_skid = 1'b1;
                    w_state_nxt      = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        if (flush) begin
            w_state_nxt      = ST_EMPTY;
            w_main_load_in   = 1'b0;
            w_main_load_skid = 1'b0;
            w_skid_load_in   = 1'b0;
        end
    end

    // Payload registers; M always holds the oldest beat, S the younger one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_main <= '0;
            r_skid <= '0;
        end else if (flush && CLEAR_DATA) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_main_load_in) begin
                r_main <= in_data;
            end else if (w_main_load_skid) begin
                r_main <= r_skid;
            end
            if (w_skid_load_in) begin
                r_skid <= in_data;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign count     = r_state;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - directed table-driven bench for pipe_skid_reg
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        c_in_ready,  n_in_ready;
    logic        c_out_valid, n_out_valid;
    logic [31:0] c_out_data,  n_out_data;
    logic [1:0]  c_count,     n_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(32), .CLEAR_DATA(1'b1)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
        .count(c_count)
    );

    pipe_skid_reg #(.WIDTH(32), .CLEAR_DATA(1'b0)) dut_keep (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
        .count(n_count)
    );

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic [31:0] ed;
        logic        cd;
        logic [1:0]  ec;
        logic        eir;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic iv, logic [31:0] d, logic ordy, logic fl,
                                logic ev, logic [31:0] ed, logic cd, logic [1:0] ec, logic eir);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.ev = ev; v.ed = ed; v.cd = cd; v.ec = ec; v.eir = eir;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        resetn = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);

        // Streaming 1..8, then drain.
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(1, i, 1, 0, 1, i, 1, 2'd1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 2'd0, 1));
        // Skid: stall for three cycles starting with beat 2.
        vecs.push_back(mk(1, 1, 1, 0, 1, 1, 1, 2'd1, 1));
        vecs.push_back(mk(1, 2, 0, 0, 1, 1, 1, 2'd2, 0));
        vecs.push_back(mk(1, 3, 0, 0, 1, 1, 1, 2'd2, 0));
        vecs.push_back(mk(1, 3, 0, 0, 1, 1, 1, 2'd2, 0));
        vecs.push_back(mk(1, 3, 1, 0, 1, 2, 1, 2'd1, 1));
        vecs.push_back(mk(1, 3, 1, 0, 1, 3, 1, 2'd1, 1));
        vecs.push_back(mk(1, 4, 1, 0, 1, 4, 1, 2'd1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 2'd0, 1));
        // Flush in FULL with M=5, S=6 and out_ready=1; input 7 in flush cycle is dropped.
        vecs.push_back(mk(1, 5, 0, 0, 1, 5, 1, 2'd1, 1));
        vecs.push_back(mk(1, 6, 0, 0, 1, 5, 1, 2'd2, 0));
        vecs.push_back(mk(1, 7, 1, 1, 0, 0, 1, 2'd0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 2'd0, 1));

        // Reset holds everything idle even with valid input present.
        tick();
        tick();
        chk("rst_out_valid", c_out_valid, 1'b0);
        chk("rst_count",     c_count, 2'd0);
        chk("rst_in_ready",  c_in_ready, 1'b1);
        chk("rst_out_data",  c_out_data, 32'h0);
        chk("rst_out_data_keep", n_out_data, 32'h0);
        resetn = 1'b1;
        tick();
        chk("first_valid", c_out_valid, 1'b1);
        chk("first_data",  c_out_data, 32'hDEAD_BEEF);
        chk("first_count", c_count, 2'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("first_drain_valid", c_out_valid, 1'b0);

        foreach (vecs[k]) begin
            drive(vecs[k].iv, vecs[k].d, vecs[k].ordy, vecs[k].fl);
            tick();
            chk($sformatf("v%0d_out_valid", k), c_out_valid, vecs[k].ev);
            chk($sformatf("v%0d_count", k),     c_count, vecs[k].ec);
            chk($sformatf("v%0d_in_ready", k),  c_in_ready, vecs[k].eir);
            chk($sformatf("v%0d_keep_valid", k), n_out_valid, vecs[k].ev);
            if (vecs[k].cd)
                chk($sformatf("v%0d_out_data", k), c_out_data, vecs[k].ed);
        end

        // CLEAR_DATA=0: flush in ONE keeps M's value but drops the flush-cycle input.
        drive(1'b1, 32'h1234, 1'b0, 1'b0);
        tick();
        chk("keep_load_valid", n_out_valid, 1'b1);
        chk("keep_load_data",  n_out_data, 32'h1234);
        drive(1'b1, 32'h5555, 1'b0, 1'b1);
        tick();
        chk("keep_flush_valid", n_out_valid, 1'b0);
        chk("keep_flush_count", n_count, 2'd0);
        chk("keep_flush_data",  n_out_data, 32'h1234);
        chk("clr_flush_data",   c_out_data, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("keep_after_valid", n_out_valid, 1'b0);
        chk("keep_after_data",  n_out_data, 32'h1234);

        // Asynchronous reset while FULL.
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        tick();
        chk("async_pre_count", c_count, 2'd2);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_out_valid", c_out_valid, 1'b0);
        chk("async_count",     c_count, 2'd0);
        chk("async_in_ready",  c_in_ready, 1'b1);
        chk("async_out_data",  c_out_data, 32'h0);
        chk("async_keep_valid", n_out_valid, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        resetn = 1'b1;
        tick();
        chk("post_async_valid", c_out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
